// File: rtl/bp_common_pkg.sv
// Shared commit/trace record declarations for the commit writeback aligner.
// Record typedefs are macros so each user picks its own field widths.
package bp_common_pkg;
    localparam int unsigned bp_x0_addr_gp = 0;
endpackage

`define DECLARE_BP_COMMIT_ENTRY_S(vaddr_w, instr_w, dword_w, reg_w, itag_w) \
    typedef struct packed {                                                    \
        logic [vaddr_w-1:0] pc;                                                \
        logic [instr_w-1:0] instr;                                             \
        logic [itag_w-1:0]  itag;                                              \
        logic               rd_w_v;                                            \
        logic               late;                                              \
        logic [reg_w-1:0]   rd_addr;                                           \
        logic [dword_w-1:0] rd_data;                                           \
    } bp_commit_entry_s

`define DECLARE_BP_TRACE_REC_S(vaddr_w, instr_w, dword_w, reg_w, itag_w) \
    typedef struct packed {                                                  \
        logic [vaddr_w-1:0] pc;                                              \
        logic [instr_w-1:0] instr;                                           \
        logic [itag_w-1:0]  itag;                                            \
        logic               rd_w_v;                                          \
        logic [reg_w-1:0]   rd_addr;                                         \
        logic [dword_w-1:0] rd_data;                                         \
    } bp_trace_rec_s

// File: rtl/bp_commit_pending_table.sv
// Per-register holding slots for late writeback data awaiting their commit record.
module bp_commit_pending_table
    import bp_common_pkg::*;
#(
    parameter int reg_addr_width_p = 5,
    parameter int dword_width_p    = 64
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        w_v_i,
    input  logic [reg_addr_width_p-1:0] w_addr_i,
    input  logic [dword_width_p-1:0]    w_data_i,
    input  logic                        clr_v_i,
    input  logic [reg_addr_width_p-1:0] clr_addr_i,
    input  logic [reg_addr_width_p-1:0] r_addr_i,
    output logic                        r_v_o,
    output logic [dword_width_p-1:0]    r_data_o,
    output logic                        conflict_o
);
    localparam int els_lp = 1 << reg_addr_width_p;

    logic [els_lp-1:0]        valid_q;
    logic [dword_width_p-1:0] data_q [els_lp];
    logic                     conflict_q;
    logic                     w_en, clr_hit;

    assign w_en    = w_v_i & (w_addr_i != reg_addr_width_p'(bp_x0_addr_gp));
    // A slot being consumed this edge is free for a fresh writeback.
    assign clr_hit = clr_v_i & (clr_addr_i == w_addr_i);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q    <= '0;
            conflict_q <= 1'b0;
        end else begin
            if (clr_v_i) valid_q[clr_addr_i] <= 1'b0;
            if (w_en) begin
                valid_q[w_addr_i] <= 1'b1;
                if (valid_q[w_addr_i] & ~clr_hit) conflict_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_en) data_q[w_addr_i] <= w_data_i;
    end

    assign r_v_o      = valid_q[r_addr_i];
    assign r_data_o   = data_q[r_addr_i];
    assign conflict_o = conflict_q;
endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based 1-read/1-write FIFO; caller only raises v_i when
// there is room (ready_o) or the head leaves the same cycle (yumi_i).
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int ptr_w_lp = $clog2(els_p);
    localparam logic [ptr_w_lp-1:0] ptr_one_lp = ptr_w_lp'(1);
    localparam logic [ptr_w_lp:0]   cnt_one_lp = (ptr_w_lp+1)'(1);
    localparam logic [ptr_w_lp:0]   cnt_max_lp = (ptr_w_lp+1)'(els_p);

    logic [ptr_w_lp-1:0] rptr_q, wptr_q;
    logic [ptr_w_lp:0]   cnt_q;
    logic [width_p-1:0]  mem_q [els_p];
    logic                enq, deq;

    assign enq     = v_i;
    assign deq     = yumi_i & v_o;
    assign v_o     = (cnt_q != '0);
    assign ready_o = (cnt_q != cnt_max_lp);
    assign data_o  = mem_q[rptr_q];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (enq) wptr_q <= wptr_q + ptr_one_lp;
            if (deq) rptr_q <= rptr_q + ptr_one_lp;
            case ({enq, deq})
                2'b10:   cnt_q <= cnt_q + cnt_one_lp;
                2'b01:   cnt_q <= cnt_q - cnt_one_lp;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr_q] <= data_i;
    end
endmodule

// File: rtl/bp_commit_wb_aligner.sv
// Merges in-order commits with late rd writebacks into complete trace records.
// Optional BP_COMMIT_ALIGN_BYPASS_EN forwards a head-matching late_wb combinationally.
module bp_commit_wb_aligner
    import bp_common_pkg::*;
#(
    parameter int vaddr_width_p    = 39,
    parameter int instr_width_p    = 32,
    parameter int dword_width_p    = 64,
    parameter int reg_addr_width_p = 5,
    parameter int fifo_els_p       = 8,
    parameter int itag_width_p     = 31
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        freeze_i,
    input  logic                        commit_v_i,
    input  logic [vaddr_width_p-1:0]    commit_pc_i,
    input  logic [instr_width_p-1:0]    commit_instr_i,
    input  logic                        commit_rd_w_v_i,
    input  logic                        commit_rd_late_i,
    input  logic [reg_addr_width_p-1:0] commit_rd_addr_i,
    input  logic [dword_width_p-1:0]    commit_rd_data_i,
    input  logic                        late_wb_v_i,
    input  logic [reg_addr_width_p-1:0] late_wb_addr_i,
    input  logic [dword_width_p-1:0]    late_wb_data_i,
    output logic                        trace_v_o,
    input  logic                        trace_ready_i,
    output logic [vaddr_width_p-1:0]    trace_pc_o,
    output logic [instr_width_p-1:0]    trace_instr_o,
    output logic [itag_width_p-1:0]     trace_itag_o,
    output logic                        trace_rd_w_v_o,
    output logic [reg_addr_width_p-1:0] trace_rd_addr_o,
    output logic [dword_width_p-1:0]    trace_rd_data_o,
    output logic                        overflow_o,
    output logic                        wb_conflict_o
);
    `DECLARE_BP_COMMIT_ENTRY_S(vaddr_width_p, instr_width_p, dword_width_p, reg_addr_width_p, itag_width_p);
    `DECLARE_BP_TRACE_REC_S(vaddr_width_p, instr_width_p, dword_width_p, reg_addr_width_p, itag_width_p);

    bp_commit_entry_s          enq_entry, head_entry;
    bp_trace_rec_s             trace_rec;
    logic [itag_width_p-1:0]   itag_q, itag_d;
    logic                      overflow_q, overflow_d;
    logic                      commit_acc, rd_nz, fifo_ready, fifo_v, enq_v, deq;
    logic                      head_ready, wb_byp, tbl_w_v, tbl_v;
    logic [dword_width_p-1:0]  tbl_data;

    assign commit_acc = commit_v_i & ~freeze_i;
    assign rd_nz      = (commit_rd_addr_i != reg_addr_width_p'(bp_x0_addr_gp));

    always_comb begin
        enq_entry         = '0;
        enq_entry.pc      = commit_pc_i;
        enq_entry.instr   = commit_instr_i;
        enq_entry.itag    = itag_q;
        enq_entry.rd_w_v  = commit_rd_w_v_i & rd_nz;
        enq_entry.late    = commit_rd_late_i & commit_rd_w_v_i & rd_nz;
        enq_entry.rd_addr = commit_rd_addr_i;
        enq_entry.rd_data = commit_rd_data_i;
    end

    // A full queue still takes the commit if the head leaves on the same edge.
    assign enq_v = commit_acc & (fifo_ready | deq);

    bsg_fifo_1r1w_small #(
        .width_p($bits(bp_commit_entry_s)),
        .els_p  (fifo_els_p)
    ) queue (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .v_i    (enq_v),
        .ready_o(fifo_ready),
        .data_i (enq_entry),
        .v_o    (fifo_v),
        .data_o (head_entry),
        .yumi_i (deq)
    );

`ifdef BP_COMMIT_ALIGN_BYPASS_EN
    assign wb_byp = fifo_v & late_wb_v_i & head_entry.late & (late_wb_addr_i == head_entry.rd_addr);
`else
    assign wb_byp = 1'b0;
`endif

    assign head_ready = fifo_v & (~head_entry.late | tbl_v | wb_byp);
    assign deq        = head_ready & trace_ready_i;
    // Forwarded data consumed on the spot never lands in the table.
    assign tbl_w_v    = late_wb_v_i & ~(wb_byp & deq);

    bp_commit_pending_table #(
        .reg_addr_width_p(reg_addr_width_p),
        .dword_width_p   (dword_width_p)
    ) pend (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .w_v_i     (tbl_w_v),
        .w_addr_i  (late_wb_addr_i),
        .w_data_i  (late_wb_data_i),
        .clr_v_i   (deq & head_entry.late),
        .clr_addr_i(head_entry.rd_addr),
        .r_addr_i  (head_entry.rd_addr),
        .r_v_o     (tbl_v),
        .r_data_o  (tbl_data),
        .conflict_o(wb_conflict_o)
    );

    always_comb begin
        itag_d     = itag_q;
        overflow_d = overflow_q;
        if (commit_acc) begin
            itag_d = itag_q + itag_width_p'(1);
            if (~fifo_ready & ~deq) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            itag_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            itag_q     <= itag_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        trace_rec.pc      = head_entry.pc;
        trace_rec.instr   = head_entry.instr;
        trace_rec.itag    = head_entry.itag;
        trace_rec.rd_w_v  = head_entry.rd_w_v;
        trace_rec.rd_addr = head_entry.rd_addr;
        trace_rec.rd_data = wb_byp          ? late_wb_data_i :
                            head_entry.late ? tbl_data       : head_entry.rd_data;
    end

    assign trace_v_o       = head_ready;
    assign trace_pc_o      = trace_rec.pc;
    assign trace_instr_o   = trace_rec.instr;
    assign trace_itag_o    = trace_rec.itag;
    assign trace_rd_w_v_o  = trace_rec.rd_w_v;
    assign trace_rd_addr_o = trace_rec.rd_addr;
    assign trace_rd_data_o = trace_rec.rd_data;
    assign overflow_o      = overflow_q;
endmodule

// File: doc/bp_commit_wb_aligner.md
Name: bp_commit_wb_aligner

Overview:
- Sits directly upstream of the non-synthesizable commit tracer.
- Merges in-order commit events from the backend with late register writebacks from long-latency ops: divide, FP, load miss.
- Emits one complete in-order record per instruction: pc, instr, itag, rd addr/data.
- Synthesizable, so it also serves on-chip trace/debug capture.

Parameters:
- vaddr_width_p, 39, PC width
- instr_width_p, 32, instruction width
- dword_width_p, 64, rd data width
- reg_addr_width_p, 5, architectural register address width
- fifo_els_p, 8, commit queue depth (power of two, >=2)
- itag_width_p, 31, instruction tag counter width

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- freeze_i  in  1  core frozen; commits ignored
- commit_v_i  in  1  instruction committed this cycle
- commit_pc_i  in  vaddr_width_p  committed PC
- commit_instr_i  in  instr_width_p  committed instruction
- commit_rd_w_v_i  in  1  instruction writes rd
- commit_rd_late_i  in  1  rd data arrives later via late_wb port
- commit_rd_addr_i  in  reg_addr_width_p  rd address
- commit_rd_data_i  in  dword_width_p  rd data (valid when not late)
- late_wb_v_i  in  1  late writeback valid
- late_wb_addr_i  in  reg_addr_width_p  late writeback rd
- late_wb_data_i  in  dword_width_p  late writeback data
- trace_v_o  out  1  record valid
- trace_ready_i  in  1  consumer accepts record
- trace_pc_o  out  vaddr_width_p  PC
- trace_instr_o  out  instr_width_p  instruction
- trace_itag_o  out  itag_width_p  tag
- trace_rd_w_v_o  out  1  record carries rd write
- trace_rd_addr_o  out  reg_addr_width_p  rd
- trace_rd_data_o  out  dword_width_p  rd data
- overflow_o  out  1  sticky: commit dropped on full queue
- wb_conflict_o  out  1  sticky: late wb hit an already-valid table slot

Behaviour:
- Reset (async, immediate): queue empty, table cleared, itag=0, overflow_o=0, wb_conflict_o=0, trace_v_o=0.
- Reset mid-operation discards all queued records and pending data; no record emitted until after release.
- Accept:
  - commit_v_i & ~freeze_i enqueues {pc, instr, itag, rd_w_v, late, rd_addr, rd_data}.
  - itag increments once per accepted commit; wraps 2^itag_width_p-1 -> 0.
- Writes to x0 are normalised: rd_addr=0 forces rd_w_v=0 and late=0.
- Full queue:
  - Enqueue while full with no same-cycle dequeue: commit dropped, itag still increments, overflow_o set until reset.
  - Full with same-cycle dequeue: accepted.
- Pending table: 2^reg_addr_width_p entries of {valid, data}.
  - late_wb_v_i writes data and sets valid at the clock edge.
  - Write to an already-valid slot overwrites it and sets wb_conflict_o.
  - late_wb with addr 0 is ignored.
- Head ready: queue non-empty and (~late or table[rd].valid).
- trace_v_o = head ready. Outputs come from the head entry; rd_data comes from the table when late.
- Dequeue on trace_v_o & trace_ready_i. A late dequeue clears table[rd].valid the same edge.
  - A simultaneous late_wb to that same rd wins: valid stays 1 with the new data.
- Latency, non-late commit: enqueue at edge N; trace_v_o at N+1 if the queue was empty.
- Latency, late commit: trace_v_o one cycle after the edge latching late_wb (table registered), or one cycle after the commit edge if the wb arrived earlier.
- Outputs hold stable while trace_v_o & ~trace_ready_i.
- Head blocked on late data stalls all younger records (strict program order).

Optional Feature:
- Macro: BP_COMMIT_ALIGN_BYPASS_EN.
- Defined: late_wb data for the head's rd bypasses the table combinationally. trace_v_o asserts in the same cycle as late_wb_v_i, with trace_rd_data_o = late_wb_data_i. If dequeued that cycle, no table write occurs.
- Undefined: one-cycle registered path only, as above.

Decomposition:
- bp_common_pkg holds:
  - a packed commit-entry struct typedef (declare macro parameterised by vaddr/instr/dword/reg widths);
  - a trace-record struct of the same fields;
  - the x0 address constant.
- Queue: existing bsg_fifo_1r1w_small.
- One natural sub-module, bp_commit_pending_table: valid/data array, write/clear ports, conflict detect, read port for head rd.

Test Plan:
- Non-late commit at cycle 10: pc=0x80000000, instr=0x00a00093, rd=1, data=0xa, ready=1 -> cycle 11: trace_v_o=1, itag=0, rd=1, data=0xa.
- Late commit: rd=5 at cycle 10, then non-late commit at 11; late_wb rd=5 data=0x1234 at 20 -> first record at 21 with data 0x1234, itag=0; second at 22, itag=1, no earlier.
- Late_wb rd=7 data=0x55 before its commit -> record emitted one cycle after commit with data 0x55; table slot 7 cleared after dequeue.
- Hold trace_ready_i=0, issue 9 commits with fifo_els_p=8 -> overflow_o=1 after the 9th; 8 records drain with itags 0..7; next accepted commit gets itag 9.
- Commit with rd=0, rd_w_v=1, late=1 -> record emitted next cycle with trace_rd_w_v_o=0, never waits.
- Assert reset_i asynchronously mid-stream with 3 queued -> trace_v_o, overflow_o, wb_conflict_o fall immediately; post-reset first commit has itag=0.
